serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that time-shares one 1-bit full_add cell to add two WIDTH-bit operands, LSB first, one bit per clock.
- Captures operands on a start pulse and shifts them through the cell, holding the carry in a flip-flop between bits.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Sits between a requester (register file or test sequencer) and the existing 1-bit adder datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A; sampled on the accepted start edge
- b  in  WIDTH  operand B; sampled on the accepted start edge
- ci  in  1  carry-in; sampled on the accepted start edge
- busy  out  1  high while state is not IDLE
- done  out  1  one-cycle pulse; result valid
- s  out  WIDTH  registered sum; held until the next accepted start
- co  out  1  registered carry-out; held like s

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, s=0, co=0.
  - Operand shift registers, carry flip-flop and bit counter are all cleared.
  - Reset asserted mid-operation aborts it. No done is produced and the old result is lost.
- States and transitions:
  - IDLE: if start=1 at edge E0, load a_sh=a, b_sh=b, cy=ci, cnt=0, then go to RUN. Otherwise stay.
  - RUN: each edge, the cell computes {co_bit,s_bit}=a_sh[0]+b_sh[0]+cy.
    - s_sh shifts right with s_bit entering at the MSB.
    - a_sh and b_sh shift right (zero fill). cy<=co_bit, cnt<=cnt+1.
    - At the edge where cnt==WIDTH-1, go to DONE and register s<=final s_sh and co<=final co_bit.
  - DONE: done=1 for exactly one cycle, then go to IDLE on the next edge.
- Latency:
  - Start sampled at E0; bits processed at edges E1..EWIDTH.
  - done is high during the cycle following EWIDTH.
  - busy is high from E0 until the edge that leaves DONE.
  - Next start is accepted at the earliest in the cycle after done.
- Handshake rules:
  - start while busy=1 (RUN or DONE) is ignored and not queued.
  - a, b and ci may change freely after E0.
- Output stability:
  - s and co change only at the RUN-to-DONE edge.
  - s and co are never updated with partial results.
- Arithmetic: unsigned modulo 2^WIDTH. co is the true carry out of bit WIDTH-1.
- cnt is $clog2(WIDTH) bits wide and does not wrap within one operation.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - When sub=1: b_sh loads ~b and cy loads 1, so the result is a-b.
  - ci is ignored when sub=1.
  - co=1 means no borrow.
- Undefined: no sub port; the block always adds.

Decomposition:
- Shared package/header:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - default WIDTH constant
- Sub-module: one instance of the existing full_add cell as the datapath.
- The controller owns only the FSM, shift registers, carry flip-flop and counter.

Test Plan (WIDTH=8):
- Basic add: a=0x0F, b=0x01, ci=0, start pulse -> done exactly 9 cycles after the start edge (cycle after E8), s=0x10, co=0, busy high E0..E9.
- Full carry chain: a=0xFF, b=0x01, ci=0 -> s=0x00, co=1; a=0x00, b=0x00, ci=1 -> s=0x01, co=0.
- Start ignored while busy:
  - Hold start=1 throughout the operation with a=0x12, b=0x34, then change the operands mid-RUN.
  - Required: s=0x46, exactly one done pulse, second operation accepted only after return to IDLE.
- Reset mid-run: assert rst_n=0 at E4 of 0xAA+0x55 -> busy=0, done never pulses, s=0, co=0; after reset, a new start completes correctly.
- Back-to-back:
  - 0x80+0x80 gives s=0x00, co=1.
  - Immediately re-start with 0x01+0x02: s and co hold 0x00/1 until the new RUN-to-DONE edge, then become 0x03/0.
- With SERIAL_ADD_SUB_EN defined: sub=1, a=0x05, b=0x07 -> s=0xFE, co=0; sub=1, a=0x07, b=0x05 -> s=0x02, co=1.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared state encoding and default width for the
// bit-serial adder controller.
package serial_add_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_full_add.sv
// full_add: 1-bit full adder cell, the datapath time-shared by the
// serial adder controller.
module full_add (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two WIDTH-bit operands LSB first, one bit per clock,
// through a single full_add cell. The carry is held in a flop between bits;
// the sum and carry-out are registered once at the end of the run and held
// until the next accepted start.
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' input selecting a-b.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             co_bit;
    logic [WIDTH-1:0] b_load;
    logic             cy_load;

    // Operand conditioning applied at capture (two's-complement subtract when enabled)
    always_comb begin
        b_load  = b;
        cy_load = ci;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_load  = ~b;
            cy_load = 1'b1;
        end
`endif
    end

    full_add u_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (cy),
        .s  (s_bit),
        .co (co_bit)
    );

    // Controller FSM: operand capture, serial shifting, carry/counter update, registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            co    <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        cy    <= cy_load;
                        s_sh  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    s_sh <= {s_bit, s_sh[WIDTH-1:1]};
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    cy   <= co_bit;
                    if (cnt == LAST) begin
                        // final bit: publish the complete word, keep cnt from wrapping
                        s     <= {s_bit, s_sh[WIDTH-1:1]};
                        co    <= co_bit;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl (WIDTH=8).
// The driver pushes the arithmetic result expected for each accepted start;
// a monitor pops and compares whenever done is seen. Protocol timing and
// output holding are checked by the driver cycle by cycle.
// Build with SERIAL_ADD_SUB_EN defined to exercise the subtract option.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;

    int unsigned  n_cmp;
    int unsigned  n_bad;
    int unsigned  n_done;
    int unsigned  n_ops;
    logic [W:0]   sb[$];
    logic [W-1:0] s_hold;
    logic         co_hold;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending result
    initial begin
        logic [W:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1, required no pending result (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("sum", 32'(s), 32'(e[W-1:0]));
                    chk("carry_out", 32'(co), 32'(e[W]));
                end
            end
        end
    end

    // One operation, entered and left at a falling edge. With hold set, start
    // stays high throughout and the operands switch to 1+1 mid-run.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci,
                         input logic tsub, input logic hold);
        logic [W:0] e;
        e = (W+1)'(ta) + (W+1)'(tb_) + (W+1)'(tci);
`ifdef SERIAL_ADD_SUB_EN
        sub = tsub;
        if (tsub) e = {(ta >= tb_) ? 1'b1 : 1'b0, W'(ta - tb_)};
`else
        if (tsub) $display("note: subtract requested without SERIAL_ADD_SUB_EN, treated as add");
`endif
        start = 1'b1;
        a     = ta;
        b     = tb_;
        ci    = tci;
        @(posedge clk);
        sb.push_back(e);
        n_ops++;
        for (int unsigned k = 1; k <= W; k++) begin
            @(negedge clk);
            if (hold) begin
                if (k == 3) begin
                    a = 8'h01;
                    b = 8'h01;
                end
            end else begin
                start = 1'(k[0]);
                a     = W'($urandom);
                b     = W'($urandom);
                ci    = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
                sub   = 1'($urandom);
`endif
            end
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            chk("s_held", 32'(s), 32'(s_hold));
            chk("co_held", 32'(co), 32'(co_hold));
            @(posedge clk);
        end
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk("done_latency", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd1);
        s_hold  = e[W-1:0];
        co_hold = e[W];
        @(posedge clk);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_cleared", 32'(busy), 32'd0);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        n_done  = 0;
        n_ops   = 0;
        s_hold  = '0;
        co_hold = 1'b0;
        rst_n   = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        ci      = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic add and carry-chain boundaries
        do_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);

        // start held through busy; operands swapped mid-run; the held start
        // is accepted again only once the block is back in IDLE
        do_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        @(negedge clk);

        // reset asserted at E4 of 0xAA+0x55 aborts without done
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        ci    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_s", 32'(s), 32'd0);
        chk("abort_co", 32'(co), 32'd0);
        s_hold  = '0;
        co_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("no_done_after_abort", 32'(done), 32'd0);
        end
        do_op(8'h3C, 8'h42, 1'b1, 1'b0, 1'b0);

        // back-to-back: second start in the cycle after done
        do_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        do_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        do_op(8'h05, 8'h07, 1'b1, 1'b1, 1'b0);
        do_op(8'h07, 8'h05, 1'b0, 1'b1, 1'b0);
        do_op(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
`endif

        // randomized operations
        for (int unsigned i = 0; i < 24; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b0);
        end
`ifdef SERIAL_ADD_SUB_EN
        for (int unsigned i = 0; i < 12; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, 1'b0);
        end
`endif

        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(sb.size()), 32'd0);
        chk("done_count", n_done, n_ops);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
